// File: rtl/inst_fetcher_pkg.sv
// Shared constants, state type and PC helper for the instruction fetch stage.
package inst_fetcher_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ICACHE_LINES   = 128;
  localparam int ICACHE_INDEX_W = 7;

  typedef enum logic {
    FETCH,
    WAIT_MEM
  } fetch_state_e;

  function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Bundles the memory-controller, issue-stage and ROB handshakes of the fetch stage.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic                  out_mem_ce;
  logic [DATA_WIDTH-1:0] out_mem_addr;
  logic                  in_mem_ce;
  logic [DATA_WIDTH-1:0] in_mem_data;
  logic                  in_issue_full;
  logic                  out_issue_valid;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  in_rob_misbranch;
  logic [DATA_WIDTH-1:0] in_rob_newpc;

  modport master (
    output out_mem_ce, out_mem_addr, out_issue_valid, out_inst, out_pc,
    input  in_mem_ce, in_mem_data, in_issue_full, in_rob_misbranch, in_rob_newpc
  );

  modport slave (
    input  out_mem_ce, out_mem_addr, out_issue_valid, out_inst, out_pc,
    output in_mem_ce, in_mem_data, in_issue_full, in_rob_misbranch, in_rob_newpc
  );

endinterface

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped one-word-per-line instruction cache with combinational lookup.
// Addresses are word addresses (byte address bits [31:2]).
module inst_fetcher_icache
  import inst_fetcher_pkg::*;
#(
  parameter int LINES   = ICACHE_LINES,
  parameter int INDEX_W = ICACHE_INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [29:0]           addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  input  logic [29:0]           waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  localparam int TAG_W = 30 - INDEX_W;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tagMem  [LINES];
  logic [DATA_WIDTH-1:0] dataMem [LINES];

  logic [INDEX_W-1:0] readIdx;
  logic [INDEX_W-1:0] writeIdx;

  assign readIdx  = addr[INDEX_W-1:0];
  assign writeIdx = waddr[INDEX_W-1:0];
  assign hit      = valid_q[readIdx] && (tagMem[readIdx] == addr[29:INDEX_W]);
  assign data     = dataMem[readIdx];

  // Only the valid bits need clearing; tag and data are don't-care until valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[writeIdx] <= TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tagMem[writeIdx]  <= waddr[29:INDEX_W];
      dataMem[writeIdx] <= wdata;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: holds the PC, serves hits from the icache and
// refills it one word at a time from the memory controller on a miss.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int ICACHE_LINES = inst_fetcher_pkg::ICACHE_LINES,
  parameter int INDEX_W      = inst_fetcher_pkg::ICACHE_INDEX_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  inst_fetcher_if.master bus
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] outPc_q, outPc_d;
  logic                  memCe_q, memCe_d;
  logic                  issueValid_q, issueValid_d;

  logic                  cacheHit;
  logic [DATA_WIDTH-1:0] cacheData;
  logic                  fillEn;

  inst_fetcher_icache #(
    .LINES   (ICACHE_LINES),
    .INDEX_W (INDEX_W)
  ) u_icache (
    .clk   (clk),
    .rst   (rst),
    .addr  (pc_q[31:2]),
    .hit   (cacheHit),
    .data  (cacheData),
    .we    (fillEn && rdy),
    .waddr (memAddr_q[31:2]),
    .wdata (bus.in_mem_data)
  );

  // A reply always fills at the held address, even when a misbranch lands in
  // the same cycle, since the data still belongs to that address.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    memAddr_d    = memAddr_q;
    inst_d       = inst_q;
    outPc_d      = outPc_q;
    memCe_d      = FALSE;
    issueValid_d = FALSE;
    fillEn       = FALSE;

    if (state_q == WAIT_MEM && bus.in_mem_ce) begin
      fillEn  = TRUE;
      state_d = FETCH;
    end

    if (bus.in_rob_misbranch) begin
      pc_d    = bus.in_rob_newpc;
      state_d = FETCH;
    end else if (state_q == FETCH) begin
      if (cacheHit) begin
        if (!bus.in_issue_full) begin
          issueValid_d = TRUE;
          inst_d       = cacheData;
          outPc_d      = pc_q;
          pc_d         = next_pc(pc_q);
        end
      end else begin
        memCe_d   = TRUE;
        memAddr_d = pc_q;
        state_d   = WAIT_MEM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= ZERO_DATA;
      memAddr_q    <= ZERO_DATA;
      inst_q       <= ZERO_DATA;
      outPc_q      <= ZERO_DATA;
      memCe_q      <= FALSE;
      issueValid_q <= FALSE;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      memAddr_q    <= memAddr_d;
      inst_q       <= inst_d;
      outPc_q      <= outPc_d;
      memCe_q      <= memCe_d;
      issueValid_q <= issueValid_d;
    end
  end

  assign bus.out_mem_ce      = memCe_q;
  assign bus.out_mem_addr    = memAddr_q;
  assign bus.out_issue_valid = issueValid_q;
  assign bus.out_inst        = inst_q;
  assign bus.out_pc          = outPc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus a randomized
// run against an abstract program-order / cache-contents reference model.
module tb_inst_fetcher;

  logic clk;
  logic rst;
  logic rdy;

  int testsRun;
  int failCount;

  inst_fetcher_if bus ();

  inst_fetcher dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Backing memory contents as seen through the memory controller.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst                  = 1'b1;
    rdy                  = 1'b1;
    bus.in_mem_ce        = 1'b0;
    bus.in_mem_data      = '0;
    bus.in_issue_full    = 1'b0;
    bus.in_rob_misbranch = 1'b0;
    bus.in_rob_newpc     = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitReq(output logic [31:0] addr, output bit seen);
    seen = 1'b0;
    addr = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (bus.out_mem_ce === 1'b1) begin
        seen = 1'b1;
        addr = bus.out_mem_addr;
      end
    end
  endtask

  task automatic reply(input logic [31:0] d);
    repeat (3) tick();
    bus.in_mem_ce   = 1'b1;
    bus.in_mem_data = d;
    tick();
    bus.in_mem_ce   = 1'b0;
  endtask

  task automatic misbranch(input logic [31:0] target);
    bus.in_rob_misbranch = 1'b1;
    bus.in_rob_newpc     = target;
    tick();
    bus.in_rob_misbranch = 1'b0;
  endtask

  task automatic test_reset();
    rst                  = 1'b1;
    rdy                  = 1'b1;
    bus.in_mem_ce        = 1'b1;
    bus.in_mem_data      = 32'hDEAD_BEEF;
    bus.in_issue_full    = 1'b0;
    bus.in_rob_misbranch = 1'b1;
    bus.in_rob_newpc     = 32'h0000_0100;
    tick();
    tick();
    testsRun++;
    if ({bus.out_mem_ce, bus.out_issue_valid} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL reset_strobes: got ce=%b valid=%b, expected 0 0", bus.out_mem_ce, bus.out_issue_valid);
    end
    testsRun++;
    if (bus.out_mem_addr !== 32'h0 || bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_values: got addr=%h inst=%h pc=%h, expected all 0", bus.out_mem_addr, bus.out_inst, bus.out_pc);
    end
  endtask

  task automatic test_cold_start();
    logic [31:0] a;
    bit seen;
    doReset();
    waitReq(a, seen);
    testsRun++;
    if (!seen || a !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL cold_req: got seen=%b addr=%h, expected 1 00000000", seen, a);
    end
    tick();
    testsRun++;
    if (bus.out_mem_ce !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cold_pulse_width: got ce=%b, expected 0", bus.out_mem_ce);
    end
    reply(32'h0000_0013);
    testsRun++;
    if (bus.out_issue_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cold_fill_no_issue: got valid=%b, expected 0", bus.out_issue_valid);
    end
    tick();
    testsRun++;
    if (bus.out_issue_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0000_0013) begin
      failCount++;
      $display("[TB] FAIL cold_issue: got valid=%b pc=%h inst=%h, expected 1 00000000 00000013",
               bus.out_issue_valid, bus.out_pc, bus.out_inst);
    end
  endtask

  task automatic test_warm_loop();
    logic [31:0] a;
    bit seen;
    doReset();
    for (int k = 0; k < 3; k++) begin
      waitReq(a, seen);
      testsRun++;
      if (!seen || a !== k * 4) begin
        failCount++;
        $display("[TB] FAIL warm_req[%0d]: got seen=%b addr=%h, expected 1 %h", k, seen, a, k * 4);
      end
      reply(memWord(k * 4));
      tick();
      testsRun++;
      if (bus.out_issue_valid !== 1'b1 || bus.out_pc !== k * 4) begin
        failCount++;
        $display("[TB] FAIL warm_fill_issue[%0d]: got valid=%b pc=%h, expected 1 %h", k, bus.out_issue_valid, bus.out_pc, k * 4);
      end
    end
    waitReq(a, seen);
    testsRun++;
    if (!seen || a !== 32'hC) begin
      failCount++;
      $display("[TB] FAIL warm_req_next: got seen=%b addr=%h, expected 1 0000000c", seen, a);
    end
    misbranch(32'h0);
    testsRun++;
    if (bus.out_issue_valid !== 1'b0 || bus.out_mem_ce !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL warm_redirect: got valid=%b ce=%b, expected 0 0", bus.out_issue_valid, bus.out_mem_ce);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      testsRun++;
      if (bus.out_issue_valid !== 1'b1 || bus.out_mem_ce !== 1'b0 || bus.out_pc !== k * 4 || bus.out_inst !== memWord(k * 4)) begin
        failCount++;
        $display("[TB] FAIL warm_hit[%0d]: got valid=%b ce=%b pc=%h inst=%h, expected 1 0 %h %h",
                 k, bus.out_issue_valid, bus.out_mem_ce, bus.out_pc, bus.out_inst, k * 4, memWord(k * 4));
      end
    end
  endtask

  // Relies on the cache warmed by test_warm_loop (PCs 0, 4, 8).
  task automatic test_stall();
    bus.in_issue_full = 1'b1;
    misbranch(32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      testsRun++;
      if (bus.out_issue_valid !== 1'b0 || bus.out_mem_ce !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b ce=%b, expected 0 0", k, bus.out_issue_valid, bus.out_mem_ce);
      end
    end
    bus.in_issue_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      testsRun++;
      if (bus.out_issue_valid !== 1'b1 || bus.out_pc !== k * 4 || bus.out_inst !== memWord(k * 4)) begin
        failCount++;
        $display("[TB] FAIL stall_release[%0d]: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                 k, bus.out_issue_valid, bus.out_pc, bus.out_inst, k * 4, memWord(k * 4));
      end
    end
  endtask

  task automatic test_misbranch_wait();
    logic [31:0] a;
    bit seen;
    doReset();
    misbranch(32'h40);
    waitReq(a, seen);
    testsRun++;
    if (!seen || a !== 32'h40) begin
      failCount++;
      $display("[TB] FAIL mbw_req: got seen=%b addr=%h, expected 1 00000040", seen, a);
    end
    tick();
    tick();
    misbranch(32'h100);
    testsRun++;
    if (bus.out_mem_ce !== 1'b0 || bus.out_issue_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mbw_flush: got ce=%b valid=%b, expected 0 0", bus.out_mem_ce, bus.out_issue_valid);
    end
    tick();
    testsRun++;
    if (bus.out_mem_ce !== 1'b1 || bus.out_mem_addr !== 32'h100) begin
      failCount++;
      $display("[TB] FAIL mbw_new_req: got ce=%b addr=%h, expected 1 00000100", bus.out_mem_ce, bus.out_mem_addr);
    end
    reply(memWord(32'h100));
    tick();
    testsRun++;
    if (bus.out_issue_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_inst !== memWord(32'h100)) begin
      failCount++;
      $display("[TB] FAIL mbw_issue: got valid=%b pc=%h inst=%h, expected 1 00000100 %h",
               bus.out_issue_valid, bus.out_pc, bus.out_inst, memWord(32'h100));
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      testsRun++;
      if (bus.out_issue_valid === 1'b1 && bus.out_pc === 32'h40) begin
        failCount++;
        $display("[TB] FAIL mbw_stale_issue: got pc=%h issued, expected no issue of 00000040", bus.out_pc);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] a;
    bit seen;
    doReset();
    misbranch(32'h80);
    waitReq(a, seen);
    testsRun++;
    if (!seen || a !== 32'h80) begin
      failCount++;
      $display("[TB] FAIL same_req: got seen=%b addr=%h, expected 1 00000080", seen, a);
    end
    repeat (4) tick();
    bus.in_mem_ce        = 1'b1;
    bus.in_mem_data      = memWord(32'h80);
    bus.in_rob_misbranch = 1'b1;
    bus.in_rob_newpc     = 32'h200;
    tick();
    bus.in_mem_ce        = 1'b0;
    bus.in_rob_misbranch = 1'b0;
    testsRun++;
    if (bus.out_issue_valid !== 1'b0 || bus.out_mem_ce !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL same_no_issue: got valid=%b ce=%b, expected 0 0", bus.out_issue_valid, bus.out_mem_ce);
    end
    tick();
    testsRun++;
    if (bus.out_mem_ce !== 1'b1 || bus.out_mem_addr !== 32'h200) begin
      failCount++;
      $display("[TB] FAIL same_new_req: got ce=%b addr=%h, expected 1 00000200", bus.out_mem_ce, bus.out_mem_addr);
    end
    reply(memWord(32'h200));
    tick();
    testsRun++;
    if (bus.out_issue_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
      failCount++;
      $display("[TB] FAIL same_issue_200: got valid=%b pc=%h, expected 1 00000200", bus.out_issue_valid, bus.out_pc);
    end
    misbranch(32'h80);
    tick();
    testsRun++;
    if (bus.out_issue_valid !== 1'b1 || bus.out_mem_ce !== 1'b0 || bus.out_pc !== 32'h80 || bus.out_inst !== memWord(32'h80)) begin
      failCount++;
      $display("[TB] FAIL same_fill_hit: got valid=%b ce=%b pc=%h inst=%h, expected 1 0 00000080 %h",
               bus.out_issue_valid, bus.out_mem_ce, bus.out_pc, bus.out_inst, memWord(32'h80));
    end
  endtask

  task automatic test_conflict();
    logic [31:0] a;
    logic [31:0] target;
    logic [31:0] word;
    bit seen;
    doReset();
    for (int k = 0; k < 4; k++) begin
      target = (k % 2 == 1) ? 32'h200 : 32'h0;
      word   = memWord(target) ^ k;
      waitReq(a, seen);
      testsRun++;
      if (!seen || a !== target) begin
        failCount++;
        $display("[TB] FAIL conflict_req[%0d]: got seen=%b addr=%h, expected 1 %h", k, seen, a, target);
      end
      reply(word);
      tick();
      testsRun++;
      if (bus.out_issue_valid !== 1'b1 || bus.out_pc !== target || bus.out_inst !== word) begin
        failCount++;
        $display("[TB] FAIL conflict_issue[%0d]: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                 k, bus.out_issue_valid, bus.out_pc, bus.out_inst, target, word);
      end
      misbranch((k % 2 == 1) ? 32'h0 : 32'h200);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] a;
    bit seen;
    doReset();
    waitReq(a, seen);
    rst = 1'b1;
    tick();
    testsRun++;
    if (bus.out_mem_ce !== 1'b0 || bus.out_mem_addr !== 32'h0 || bus.out_issue_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midmiss_reset: got ce=%b addr=%h valid=%b, expected 0 00000000 0",
               bus.out_mem_ce, bus.out_mem_addr, bus.out_issue_valid);
    end
    rst                  = 1'b0;
    bus.in_mem_ce        = 1'b1;
    bus.in_mem_data      = 32'hBAAD_BAAD;
    bus.in_rob_misbranch = 1'b1;
    bus.in_rob_newpc     = 32'h300;
    tick();
    bus.in_mem_ce        = 1'b0;
    bus.in_rob_misbranch = 1'b0;
    waitReq(a, seen);
    testsRun++;
    if (!seen || a !== 32'h300) begin
      failCount++;
      $display("[TB] FAIL midmiss_req300: got seen=%b addr=%h, expected 1 00000300", seen, a);
    end
    misbranch(32'h0);
    waitReq(a, seen);
    testsRun++;
    if (!seen || a !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL midmiss_late_ignored: got seen=%b addr=%h, expected 1 00000000", seen, a);
    end
  endtask

  // Reference model: program-order PC plus a map of which address each
  // cache index currently holds; an outstanding request means no fetch.
  task automatic test_random();
    logic [31:0] cacheAddr [128];
    bit          cacheValid [128];
    logic [31:0] expPc;
    logic [31:0] pendAddr;
    bit          pending;
    int          countdown;
    int          issued;
    bit          r, f, m, mc;
    logic [31:0] np;
    bit          expIssue, expReq;
    logic [31:0] expIssuePc, expReqAddr;
    logic [97:0] snap;
    int          idx;

    doReset();
    for (int i = 0; i < 128; i++) begin
      cacheValid[i] = 1'b0;
      cacheAddr[i]  = '0;
    end
    expPc     = 32'h0;
    pending   = 1'b0;
    pendAddr  = '0;
    countdown = 0;
    issued    = 0;

    for (int c = 0; c < 1500; c++) begin
      r  = ($urandom_range(0, 9) != 0);
      f  = ($urandom_range(0, 3) == 0);
      m  = r && ($urandom_range(0, 24) == 0);
      np = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom_range(0, 511) << 2);
      mc = r && pending && (countdown == 0);
      if (pending && countdown > 0) countdown--;

      rdy                  = r;
      bus.in_issue_full    = f;
      bus.in_rob_misbranch = m;
      bus.in_rob_newpc     = np;
      bus.in_mem_ce        = mc;
      bus.in_mem_data      = mc ? memWord(pendAddr) : $urandom();
      snap = {bus.out_mem_ce, bus.out_mem_addr, bus.out_issue_valid, bus.out_inst, bus.out_pc};

      expIssue   = 1'b0;
      expReq     = 1'b0;
      expIssuePc = '0;
      expReqAddr = '0;
      if (r) begin
        if (mc) begin
          idx = int'((pendAddr >> 2) % 128);
          cacheValid[idx] = 1'b1;
          cacheAddr[idx]  = pendAddr;
        end
        idx = int'((expPc >> 2) % 128);
        if (m) begin
          expPc   = np;
          pending = 1'b0;
        end else if (pending) begin
          if (mc) pending = 1'b0;
        end else if (cacheValid[idx] && cacheAddr[idx] == expPc) begin
          if (!f) begin
            expIssue   = 1'b1;
            expIssuePc = expPc;
            expPc      = expPc + 32'd4;
          end
        end else begin
          expReq     = 1'b1;
          expReqAddr = expPc;
          pending    = 1'b1;
          pendAddr   = expPc;
          countdown  = $urandom_range(4, 8);
        end
      end

      tick();

      if (!r) begin
        testsRun++;
        if ({bus.out_mem_ce, bus.out_mem_addr, bus.out_issue_valid, bus.out_inst, bus.out_pc} !== snap) begin
          failCount++;
          $display("[TB] FAIL rand_freeze[%0d]: got %h, expected %h", c,
                   {bus.out_mem_ce, bus.out_mem_addr, bus.out_issue_valid, bus.out_inst, bus.out_pc}, snap);
        end
      end else begin
        testsRun++;
        if (bus.out_issue_valid !== expIssue) begin
          failCount++;
          $display("[TB] FAIL rand_issue_valid[%0d]: got %b, expected %b", c, bus.out_issue_valid, expIssue);
        end
        if (expIssue) begin
          issued++;
          testsRun++;
          if (bus.out_pc !== expIssuePc || bus.out_inst !== memWord(expIssuePc)) begin
            failCount++;
            $display("[TB] FAIL rand_issue_data[%0d]: got pc=%h inst=%h, expected %h %h",
                     c, bus.out_pc, bus.out_inst, expIssuePc, memWord(expIssuePc));
          end
        end
        testsRun++;
        if (bus.out_mem_ce !== expReq) begin
          failCount++;
          $display("[TB] FAIL rand_mem_ce[%0d]: got %b, expected %b", c, bus.out_mem_ce, expReq);
        end
        if (expReq) begin
          testsRun++;
          if (bus.out_mem_addr !== expReqAddr) begin
            failCount++;
            $display("[TB] FAIL rand_mem_addr[%0d]: got %h, expected %h", c, bus.out_mem_addr, expReqAddr);
          end
        end
      end
    end
    rdy = 1'b1;
    testsRun++;
    if (issued < 20) begin
      failCount++;
      $display("[TB] FAIL rand_progress: got %0d issues, expected at least 20", issued);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst       = 1'b1;
    rdy       = 1'b1;
    bus.in_mem_ce        = 1'b0;
    bus.in_mem_data      = '0;
    bus.in_issue_full    = 1'b0;
    bus.in_rob_misbranch = 1'b0;
    bus.in_rob_newpc     = '0;

    test_reset();
    test_cold_start();
    test_warm_loop();
    test_stall();
    test_misbranch_wait();
    test_same_cycle();
    test_conflict();
    test_reset_mid_miss();
    test_random();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
